// File: rtl/player_action_encoder_if.sv
// Button, tick and action signals between the input driver and the player action encoder.
interface player_action_encoder_if;
  logic       tick;
  logic [5:0] btn_raw;
  logic [5:0] action;
  logic       action_valid;
  logic       airborne;
  logic       cooldown_active;

  modport master (
    output tick, btn_raw,
    input  action, action_valid, airborne, cooldown_active
  );

  modport slave (
    input  tick, btn_raw,
    output action, action_valid, airborne, cooldown_active
  );
endinterface

// File: rtl/player_action_encoder.sv
// Turns six raw push-buttons into one one-hot action per game tick.
// Inputs are synchronised, debounced and edge-detected; jump airtime and attack cooldown apply.
module player_action_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JUMP_TICKS      = 2,
  parameter int unsigned COOLDOWN_TICKS  = 1
) (
  input logic                   clk,
  input logic                   rst,
  player_action_encoder_if.slave bus
);

  localparam logic [5:0] ActIdle  = 6'b000000;
  localparam logic [5:0] ActRight = 6'b100000;
  localparam logic [5:0] ActLeft  = 6'b010000;
  localparam logic [5:0] ActWait  = 6'b001000;
  localparam logic [5:0] ActJump  = 6'b000100;
  localparam logic [5:0] ActKick  = 6'b000010;
  localparam logic [5:0] ActPunch = 6'b000001;

  localparam logic [7:0] DbLimit  = 8'(DEBOUNCE_CYCLES);
  localparam logic [2:0] JumpLoad = 3'(JUMP_TICKS - 1);
  localparam logic [2:0] CdLoad   = 3'(COOLDOWN_TICKS);

  logic [5:0] sync1_q, sync2_q;
  logic [5:0] stable_q, stable_d, stable_dly_q;
  logic [5:0] pending_q, pending_d;
  logic [5:0] rise;
  logic [7:0] db_cnt_q [6];
  logic [7:0] db_cnt_d [6];
  logic [2:0] jump_cnt_q, jump_cnt_d;
  logic [2:0] cd_cnt_q, cd_cnt_d;
  logic [5:0] action_q, action_d;
  logic [5:0] cand;
  logic       valid_q;
  logic       attack;

  // Counter runs only while the synchronised level disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 6; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] + 8'd1 == DbLimit) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  always_comb begin
    cand = pending_q;
    if (cd_cnt_q != 3'd0) cand[1:0] = 2'b00;
    if (cand[5] && cand[4]) cand[5:4] = 2'b00;

    action_d   = action_q;
    jump_cnt_d = jump_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    attack     = 1'b0;
    pending_d  = pending_q | rise;

    if (bus.tick) begin
      // Edges arriving with the tick survive the clear and count for the next tick.
      pending_d = rise;
      if (jump_cnt_q != 3'd0) begin
        action_d   = ActJump;
        jump_cnt_d = jump_cnt_q - 3'd1;
      end else if (cand[0]) begin
        action_d = ActPunch;
        attack   = 1'b1;
      end else if (cand[1]) begin
        action_d = ActKick;
        attack   = 1'b1;
      end else if (cand[2]) begin
        action_d   = ActJump;
        jump_cnt_d = JumpLoad;
      end else if (cand[4]) begin
        action_d = ActLeft;
      end else if (cand[5]) begin
        action_d = ActRight;
      end else if (cand[3]) begin
        action_d = ActWait;
      end else begin
        action_d = ActIdle;
      end

      if (attack) begin
        cd_cnt_d = CdLoad;
      end else if (cd_cnt_q != 3'd0) begin
        cd_cnt_d = cd_cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      db_cnt_q     <= '{default: '0};
      pending_q    <= '0;
      jump_cnt_q   <= '0;
      cd_cnt_q     <= '0;
      action_q     <= ActIdle;
      valid_q      <= 1'b0;
    end else begin
      sync1_q      <= bus.btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      db_cnt_q     <= db_cnt_d;
      pending_q    <= pending_d;
      jump_cnt_q   <= jump_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      action_q     <= action_d;
      valid_q      <= bus.tick;
    end
  end

  assign bus.action          = action_q;
  assign bus.action_valid    = valid_q;
  assign bus.airborne        = (jump_cnt_q != 3'd0);
  assign bus.cooldown_active = (cd_cnt_q != 3'd0);

endmodule

// File: tb/tb_player_action_encoder.sv
// Randomised scoreboard bench for player_action_encoder against a press/tick level model.
module tb_player_action_encoder;

  localparam int unsigned Db   = 4;
  localparam int unsigned Jump = 2;
  localparam int unsigned Cd   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_action_encoder_if bus ();

  player_action_encoder #(
    .DEBOUNCE_CYCLES(Db),
    .JUMP_TICKS     (Jump),
    .COOLDOWN_TICKS (Cd)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected {action, airborne, cooldown_active} per tick.
  logic [7:0] exp_q[$];

  // Model state: presses waiting for a tick, remaining airtime, remaining cooldown.
  logic [5:0] m_pending;
  int         m_air;
  int         m_cd;
  int         order[6] = '{0, 1, 2, 4, 5, 3};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_air     = 0;
    m_cd      = 0;
  endtask

  task automatic model_tick();
    logic [5:0] cand;
    logic [5:0] act;
    act = '0;
    if (m_air > 0) begin
      act = 6'b000100;
      m_air--;
      if (m_cd > 0) m_cd--;
    end else begin
      cand = m_pending;
      if (m_cd > 0) cand[1:0] = 2'b00;
      if (cand[5] && cand[4]) cand[5:4] = 2'b00;
      for (int k = 0; k < 6; k++) begin
        if (cand[order[k]]) begin
          act = 6'b1 << order[k];
          break;
        end
      end
      if (act == 6'b000100) m_air = Jump - 1;
      if (act == 6'b000001 || act == 6'b000010) m_cd = Cd;
      else if (m_cd > 0) m_cd--;
    end
    m_pending = '0;
    exp_q.push_back({act, (m_air != 0), (m_cd != 0)});
  endtask

  task automatic do_tick();
    model_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  // A press counts when the raw level stays high for at least Db cycles.
  task automatic press(input logic [5:0] mask, input int hold);
    bus.btn_raw = mask;
    cyc(hold);
    bus.btn_raw = '0;
    cyc(Db + 4);
    if (hold >= Db) m_pending |= mask;
  endtask

  always @(negedge clk) begin
    if (bus.action_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {bus.action, bus.airborne, bus.cooldown_active}, 8'hxx);
      end else begin
        check("tick_action", {bus.action, bus.airborne, bus.cooldown_active}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int ticks;
    bus.tick    = 1'b0;
    bus.btn_raw = '0;
    model_reset();
    cyc(3);
    check("reset_state", {1'b0, bus.action, bus.action_valid, bus.airborne, bus.cooldown_active},
          8'h00);
    rst = 1'b0;
    cyc(2);

    // Directed sequences from the block's intended use.
    press(6'b000001, Db - 1);  do_tick();                       // glitch rejected
    press(6'b000010, 10);      do_tick(); cyc(3); do_tick();    // kick then idle
    press(6'b111000, 6);       do_tick(); cyc(2);               // left/right cancel
    press(6'b000111, 6);       do_tick(); cyc(2);
    press(6'b000100, 6);       do_tick(); cyc(1);               // airtime
    press(6'b000001, 6);       do_tick(); cyc(1); do_tick();
    press(6'b000001, 6);       do_tick();                       // cooldown mask
    press(6'b100001, 6);       do_tick();
    press(6'b000001, 6);       do_tick();
    press(6'b001000, 6); press(6'b001000, 6); do_tick(); do_tick();  // double press

    // Edge landing on the tick cycle belongs to the following tick.
    bus.btn_raw = 6'b010000;
    cyc(Db + 2);
    do_tick();
    m_pending |= 6'b010000;
    bus.btn_raw = '0;
    cyc(Db + 4);
    do_tick();

    // Reset while airborne, jump button held through reset.
    press(6'b000100, 6);
    do_tick();
    bus.btn_raw = 6'b000100;
    rst = 1'b1;
    cyc(1);
    check("reset_mid_jump",
          {1'b0, bus.action, bus.action_valid, bus.airborne, bus.cooldown_active}, 8'h00);
    model_reset();
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
    cyc(Db + 4);
    m_pending |= 6'b000100;
    bus.btn_raw = '0;
    cyc(Db + 4);
    do_tick();
    cyc(2);

    // Random rounds: several presses (glitches included), then 1..3 back-to-back ticks.
    for (int r = 0; r < 120; r++) begin
      n = $urandom_range(0, 3);
      for (int p = 0; p < n; p++) begin
        press(6'($urandom) & 6'($urandom | $urandom), $urandom_range(1, Db + 3));
      end
      ticks = $urandom_range(1, 3);
      for (int t = 0; t < ticks; t++) do_tick();
      cyc($urandom_range(0, 2));
    end

    cyc(4);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
